// File: rtl/nmr_seq_loop_engine.sv
// NMR pulse-sequence engine: fetches command words from SRAM and streams
// {idly,pls,edly} triplets to the bit generator, with a nested loop stack.
// Ports: CLK/RST_N, START/DONE/ERR/ERR_CODE/ABORTED/WORD_CNT status,
// SRAM_* read port (write side tied off), BT_START/BT_READY handshake,
// idly_reg/pls_reg/edly_reg triplet fields.
module nmr_seq_loop_engine #(
  parameter int IDLY_WIDTH        = 32,
  parameter int PLS_WIDTH         = 32,
  parameter int EDLY_WIDTH        = 32,
  parameter int CNT_WIDTH         = 32,
  parameter int LOOP_WIDTH        = 16,
  parameter int LOOP_DEPTH        = 4,
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int RD_LATENCY        = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  output logic                         DONE,
  output logic                         ERR,
  output logic [1:0]                   ERR_CODE,
  output logic                         ABORTED,
  output logic [31:0]                  WORD_CNT,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
  output logic                         BT_START,
  input  logic                         BT_READY,
  output logic [IDLY_WIDTH-1:0]        idly_reg,
  output logic [PLS_WIDTH-1:0]         pls_reg,
  output logic [EDLY_WIDTH-1:0]        edly_reg
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_NEXT,
    S_FIN
  } state_t;

  localparam int EDLY_LSB = CNT_WIDTH;
  localparam int PLS_LSB  = CNT_WIDTH + EDLY_WIDTH;
  localparam int IDLY_LSB = CNT_WIDTH + EDLY_WIDTH + PLS_WIDTH;
  localparam int SPW      = $clog2(LOOP_DEPTH + 1);
  localparam int IDXW     = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
  localparam int WCW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int WCINIT   = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

  localparam logic [1:0] E_OVF = 2'd1;
  localparam logic [1:0] E_UND = 2'd2;
  localparam logic [1:0] E_RUN = 2'd3;

  state_t r_state;
  state_t w_next;

  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [SPW-1:0]             r_sp;
  logic [WCW-1:0]             r_wcnt;
  logic                       r_jump;
  logic                       r_lend;
  logic                       r_cs;
  logic                       r_bt_start;
  logic                       r_done;
  logic                       r_err;
  logic [1:0]                 r_err_code;
  logic                       r_aborted;
  logic [31:0]                r_word_cnt;
  logic [IDLY_WIDTH-1:0]      r_idly;
  logic [PLS_WIDTH-1:0]       r_pls;
  logic [EDLY_WIDTH-1:0]      r_edly;

  logic [SRAM_ADDR_WIDTH-1:0] r_stk_addr [LOOP_DEPTH];
  logic [LOOP_WIDTH-1:0]      r_stk_cnt  [LOOP_DEPTH];

  logic                  w_end;
  logic                  w_lstart;
  logic                  w_lend;
  logic [LOOP_WIDTH-1:0] w_n;
  logic [LOOP_WIDTH-1:0] w_n_m1;
  logic [IDXW-1:0]       w_top_idx;
  logic [IDXW-1:0]       w_push_idx;
  logic [LOOP_WIDTH-1:0] w_top_cnt;
  logic                  w_push;
  logic                  w_loop_back;
  logic                  w_pop;
  logic                  w_inc;
  logic                  w_abort;
  logic                  w_set_err;
  logic [1:0]            w_code;
  logic                  w_unused;

  assign w_end    = SRAM_RD_DAT[2];
  assign w_lstart = SRAM_RD_DAT[1];
  assign w_lend   = SRAM_RD_DAT[0];
  assign w_n      = SRAM_RD_DAT[16 +: LOOP_WIDTH];
  // A count of zero still runs the body once.
  assign w_n_m1   = (w_n == '0) ? '0 : w_n - LOOP_WIDTH'(1);
  assign w_unused = ^SRAM_RD_DAT[15:3];

  assign w_top_idx  = (r_sp == '0) ? '0 : IDXW'(r_sp - SPW'(1));
  assign w_push_idx = IDXW'(r_sp);
  assign w_top_cnt  = r_stk_cnt[w_top_idx];

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_loop_back = 1'b0;
    w_pop       = 1'b0;
    w_inc       = 1'b0;
    w_abort     = 1'b0;
    w_set_err   = 1'b0;
    w_code      = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (START) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!START) begin
          w_next  = S_FIN;
          w_abort = 1'b1;
        end else if (RD_LATENCY > 1) begin
          w_next = S_WAIT;
        end else begin
          w_next = S_DECODE;
        end
      end
      S_WAIT: begin
        if (r_wcnt == '0) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_end) begin
          w_next = S_FIN;
        end else if (w_lstart && !r_jump) begin
          if (r_sp == SPW'(LOOP_DEPTH)) begin
            w_next    = S_FIN;
            w_set_err = 1'b1;
            w_code    = E_OVF;
          end else begin
            w_push = 1'b1;
            w_next = S_ISSUE;
          end
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (BT_READY) w_next = S_NEXT;
      end
      S_NEXT: begin
        if (!START) begin
          w_next  = S_FIN;
          w_abort = 1'b1;
        end else if (r_lend && r_sp == '0) begin
          w_next    = S_FIN;
          w_set_err = 1'b1;
          w_code    = E_UND;
        end else if (r_lend && w_top_cnt != '0) begin
          w_loop_back = 1'b1;
          w_next      = S_FETCH;
        end else begin
          w_pop = r_lend;
          // No wrap past the last word.
          if (r_addr == '1) begin
            w_next    = S_FIN;
            w_set_err = 1'b1;
            w_code    = E_RUN;
          end else begin
            w_inc  = 1'b1;
            w_next = S_FETCH;
          end
        end
      end
      S_FIN: begin
        if (!START) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr     <= '0;
      r_sp       <= '0;
      r_wcnt     <= '0;
      r_jump     <= 1'b0;
      r_lend     <= 1'b0;
      r_cs       <= 1'b0;
      r_bt_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_aborted  <= 1'b0;
      r_word_cnt <= '0;
      r_idly     <= '0;
      r_pls      <= '0;
      r_edly     <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        r_stk_addr[i] <= '0;
        r_stk_cnt[i]  <= '0;
      end
    end else begin
      r_cs       <= (w_next == S_FETCH);
      r_bt_start <= (w_next == S_ISSUE);
      r_done     <= (w_next == S_FIN);

      if (r_state == S_IDLE) begin
        r_addr     <= '0;
        r_sp       <= '0;
        r_jump     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
        r_aborted  <= 1'b0;
        r_word_cnt <= '0;
      end

      if (r_state == S_FETCH) r_wcnt <= WCW'(WCINIT);
      if (r_state == S_WAIT)  r_wcnt <= r_wcnt - WCW'(1);

      if (r_state == S_DECODE) begin
        r_idly <= SRAM_RD_DAT[IDLY_LSB +: IDLY_WIDTH];
        r_pls  <= SRAM_RD_DAT[PLS_LSB +: PLS_WIDTH];
        r_edly <= SRAM_RD_DAT[EDLY_LSB +: EDLY_WIDTH];
        r_lend <= w_lend;
        r_jump <= 1'b0;
      end

      if (w_push) begin
        r_stk_addr[w_push_idx] <= r_addr;
        r_stk_cnt[w_push_idx]  <= w_n_m1;
        r_sp                   <= r_sp + SPW'(1);
      end

      if (r_state == S_ISSUE && BT_READY)
        r_word_cnt <= r_word_cnt + 32'd1;

      // Loop-back re-fetches the loop-start word; the jump flag stops it
      // from pushing a second frame for the same loop.
      if (w_loop_back) begin
        r_stk_cnt[w_top_idx] <= w_top_cnt - LOOP_WIDTH'(1);
        r_addr               <= r_stk_addr[w_top_idx];
        r_jump               <= 1'b1;
      end

      if (w_pop) r_sp <= r_sp - SPW'(1);
      if (w_inc) r_addr <= r_addr + SRAM_ADDR_WIDTH'(1);

      if (w_abort) r_aborted <= 1'b1;
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  assign DONE        = r_done;
  assign ERR         = r_err;
  assign ERR_CODE    = r_err_code;
  assign ABORTED     = r_aborted;
  assign WORD_CNT    = r_word_cnt;
  assign SRAM_ADDR   = r_addr;
  assign SRAM_CS     = r_cs;
  assign SRAM_CLKEN  = 1'b1;
  assign SRAM_WR     = 1'b0;
  assign SRAM_WR_DAT = '0;
  assign SRAM_BYTEEN = '1;
  assign BT_START    = r_bt_start;
  assign idly_reg    = r_idly;
  assign pls_reg     = r_pls;
  assign edly_reg    = r_edly;

endmodule

// File: tb/tb_nmr_seq_loop_engine.sv
// Self-checking bench for nmr_seq_loop_engine: table-driven programs
// plus hand-written backpressure, abort and async-reset sequences.
module tb_nmr_seq_loop_engine;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         BT_READY = 1'b1;
  logic         DONE, ERR, ABORTED, SRAM_CS, SRAM_CLKEN, SRAM_WR, BT_START;
  logic [1:0]   ERR_CODE;
  logic [31:0]  WORD_CNT;
  logic [7:0]   SRAM_ADDR;
  logic [127:0] SRAM_WR_DAT;
  logic [15:0]  SRAM_BYTEEN;
  logic [127:0] SRAM_RD_DAT;
  logic [31:0]  idly_reg, pls_reg, edly_reg;

  nmr_seq_loop_engine dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .DONE(DONE), .ERR(ERR),
    .ERR_CODE(ERR_CODE), .ABORTED(ABORTED), .WORD_CNT(WORD_CNT),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CS(SRAM_CS), .SRAM_CLKEN(SRAM_CLKEN),
    .SRAM_WR(SRAM_WR), .SRAM_WR_DAT(SRAM_WR_DAT),
    .SRAM_BYTEEN(SRAM_BYTEEN), .SRAM_RD_DAT(SRAM_RD_DAT),
    .BT_START(BT_START), .BT_READY(BT_READY),
    .idly_reg(idly_reg), .pls_reg(pls_reg), .edly_reg(edly_reg)
  );

  always #5 CLK = ~CLK;

  logic [127:0] mem [256];
  always @(posedge CLK) if (SRAM_CS) SRAM_RD_DAT <= mem[SRAM_ADDR];

  int unsigned cyc = 0;
  logic [31:0] acc_q [$];
  int unsigned acc_t [$];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST_N && BT_START && BT_READY) begin
      acc_q.push_back(idly_reg);
      acc_t.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] C_END = 32'h4;
  localparam logic [31:0] C_LS  = 32'h2;
  localparam logic [31:0] C_LE  = 32'h1;

  function automatic logic [127:0] wd(input int i, input logic [31:0] c);
    logic [31:0] k;
    k = 32'(i);
    return {32'h100 + k, 32'h200 + k, 32'h300 + k, c};
  endfunction

  function automatic logic [31:0] nf(input int n);
    return 32'(n) << 16;
  endfunction

  task automatic load_prog(input int p);
    for (int i = 0; i < 256; i++) mem[i] = wd(i, 32'h0);
    case (p)
      0: mem[3] = wd(3, C_END);
      1: begin
        mem[1] = wd(1, C_LS | nf(3));
        mem[2] = wd(2, C_LS | nf(2));
        mem[3] = wd(3, C_LE);
        mem[4] = wd(4, C_LE);
        mem[5] = wd(5, C_END);
      end
      2: begin
        mem[0] = wd(0, C_LS | C_LE | nf(5));
        mem[1] = wd(1, C_END);
      end
      3: begin
        mem[0] = wd(0, C_LS | C_LE | nf(0));
        mem[1] = wd(1, C_END);
      end
      4: for (int i = 0; i < 5; i++) mem[i] = wd(i, C_LS | nf(1));
      5: mem[0] = wd(0, C_LE);
      6: ;
      7: begin
        mem[0] = wd(0, C_LS | nf(3));
        mem[1] = wd(1, C_END);
      end
      8: mem[0] = wd(0, C_END);
      default: ;
    endcase
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge CLK);
      if (DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic to_idle();
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    string name;
    int    prog;
    int    cnt;
    bit    err;
    int    code;
  } vec_t;

  vec_t tbl [9];
  logic [31:0] exp_q [$];
  logic [142:0] outs;
  logic [95:0] fsave;
  bit ok;
  bit bad;

  initial begin
    tbl[0] = '{"linear",    0, 3,   1'b0, 0};
    tbl[1] = '{"nested",    1, 19,  1'b0, 0};
    tbl[2] = '{"single5",   2, 5,   1'b0, 0};
    tbl[3] = '{"single0",   3, 1,   1'b0, 0};
    tbl[4] = '{"overflow",  4, 4,   1'b1, 1};
    tbl[5] = '{"underflow", 5, 1,   1'b1, 2};
    tbl[6] = '{"runoff",    6, 256, 1'b1, 3};
    tbl[7] = '{"unclosed",  7, 1,   1'b0, 0};
    tbl[8] = '{"end_first", 8, 0,   1'b0, 0};

    load_prog(0);
    repeat (3) @(negedge CLK);
    outs = {DONE, ERR, ERR_CODE, ABORTED, WORD_CNT, SRAM_ADDR, SRAM_CS,
            BT_START, idly_reg, pls_reg, edly_reg};
    chk("reset_outs", 64'(outs != '0), 64'd0);
    chk("tieoffs", {SRAM_CLKEN, SRAM_WR, 16'(SRAM_WR_DAT != '0), SRAM_BYTEEN},
        {1'b1, 1'b0, 16'd0, 16'hffff});
    RST_N = 1'b1;
    @(negedge CLK);

    foreach (tbl[k]) begin
      load_prog(tbl[k].prog);
      acc_q.delete();
      acc_t.delete();
      BT_READY = 1'b1;
      START = 1'b1;
      wait_done(ok);
      chk({tbl[k].name, "_done"}, 64'(ok), 64'd1);
      chk({tbl[k].name, "_cnt"}, 64'(WORD_CNT), 64'(tbl[k].cnt));
      chk({tbl[k].name, "_err"}, 64'(ERR), 64'(tbl[k].err));
      chk({tbl[k].name, "_code"}, 64'(ERR_CODE), 64'(tbl[k].code));
      chk({tbl[k].name, "_abort"}, 64'(ABORTED), 64'd0);
      chk({tbl[k].name, "_qsize"}, 64'(acc_q.size()), 64'(tbl[k].cnt));
      exp_q.delete();
      if (tbl[k].prog == 0) begin
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i));
        if (acc_t.size() == 3) begin
          chk("linear_period0", 64'(acc_t[1] - acc_t[0]), 64'd4);
          chk("linear_period1", 64'(acc_t[2] - acc_t[1]), 64'd4);
        end else begin
          chk("linear_accepts", 64'(acc_t.size()), 64'd3);
        end
      end
      if (tbl[k].prog == 1) begin
        exp_q.push_back(32'h100);
        for (int i = 0; i < 3; i++) begin
          exp_q.push_back(32'h101);
          for (int j = 0; j < 2; j++) begin
            exp_q.push_back(32'h102);
            exp_q.push_back(32'h103);
          end
          exp_q.push_back(32'h104);
        end
      end
      if (tbl[k].prog == 2) for (int i = 0; i < 5; i++) exp_q.push_back(32'h100);
      if (exp_q.size() != 0) begin
        bad = (acc_q.size() != exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
          if (acc_q[i] != exp_q[i]) bad = 1'b1;
        chk({tbl[k].name, "_order"}, 64'(bad), 64'd0);
      end
      to_idle();
      chk({tbl[k].name, "_idle"}, {62'd0, DONE, ERR}, 64'd0);
    end

    load_prog(0);
    acc_q.delete();
    BT_READY = 1'b0;
    START = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (BT_START) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_start", 64'(ok), 64'd1);
    fsave = {idly_reg, pls_reg, edly_reg};
    chk("bp_fields", 64'(fsave[95:64]), 64'h100);
    bad = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (!BT_START || {idly_reg, pls_reg, edly_reg} != fsave) bad = 1'b1;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    START = 1'b0;
    @(negedge CLK);
    chk("abort_still_issuing", 64'(BT_START), 64'd1);
    BT_READY = 1'b1;
    wait_done(ok);
    chk("abort_done", 64'(ok), 64'd1);
    chk("abort_flag", 64'(ABORTED), 64'd1);
    chk("abort_err", 64'(ERR), 64'd0);
    chk("abort_cnt", 64'(WORD_CNT), 64'd1);
    chk("abort_qsize", 64'(acc_q.size()), 64'd1);
    to_idle();

    load_prog(1);
    START = 1'b1;
    repeat (40) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    outs = {DONE, ERR, ERR_CODE, ABORTED, WORD_CNT, SRAM_ADDR, SRAM_CS,
            BT_START, idly_reg, pls_reg, edly_reg};
    chk("async_rst_outs", 64'(outs != '0), 64'd0);
    START = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    acc_q.delete();
    START = 1'b1;
    wait_done(ok);
    chk("rerun_done", 64'(ok), 64'd1);
    chk("rerun_cnt", 64'(WORD_CNT), 64'd19);
    chk("rerun_err", 64'(ERR), 64'd0);
    to_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
